ppu_pixel_sink: RTL

Responder for the PPU output handshake: accepts pixel bytes offered on a strobe/acknowledge pair, buffers them in a small synchronous FIFO, and feeds the VGA driver's pixel byte input one byte per display request. It sits between the PPU output port and the VGA driver data input. It decouples the PPU's three-cycle-per-byte handshake from the display's per-clock pixel demand, and counts underflows.

---
 rtl/ppu_sink_pkg.sv | 21 ++
 rtl/ppu_sink_fifo.sv | 48 ++++
 rtl/ppu_pixel_sink.sv | 81 ++++++++
 3 files changed

// File: rtl/ppu_sink_pkg.sv
// Shared definitions for the PPU pixel sink.
// Contents: pixel byte field positions, the frame-sync control code,
// the black fill value and the sink state encoding.
package ppu_sink_pkg;
  // Pixel byte layout: R[7:6] G[5:4] B[3:2] ctl[1:0]
  localparam int PIX_R_HI   = 7;
  localparam int PIX_R_LO   = 6;
  localparam int PIX_G_HI   = 5;
  localparam int PIX_G_LO   = 4;
  localparam int PIX_B_HI   = 3;
  localparam int PIX_B_LO   = 2;
  localparam int PIX_CTL_HI = 1;
  localparam int PIX_CTL_LO = 0;

  localparam logic [1:0] SYNC_CTL  = 2'b11;
  // Fill value driven while priming or starved. Its ctl field is 2'b00,
  // so it can never be mistaken for a frame-sync marker.
  localparam logic [7:0] BLACK_PIX = 8'h00;

  typedef enum logic {PRIME, RUN} sink_state_e;
endpackage

// File: rtl/ppu_sink_fifo.sv
// DEPTH x 8 synchronous FIFO with wrapping pointers and a separate
// occupancy counter.
// Ports: clk, rst (sync, active-low), clear (sync clear, beats push/pop),
// push/wdata, pop, rdata (head, combinational), level, full, empty.
module ppu_sink_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        wdata,
  input  logic              pop,
  output logic [7:0]        rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/ppu_pixel_sink.sv
// Responder for the PPU output strobe/ack handshake. Buffers pixel bytes
// in a small FIFO and releases one byte per display request once primed.
// Ports: clk, rst (sync, active-low); px_data_i/px_stb_i/px_ack_o (PPU
// side); pix_rd_i/pix_data_o (VGA side); flush_i; level_o;
// underflow_cnt_o (saturating count of empty reads while running).
module ppu_pixel_sink
  import ppu_sink_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int START_LEVEL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        px_data_i,
  input  logic              px_stb_i,
  output logic              px_ack_o,
  input  logic              pix_rd_i,
  output logic [7:0]        pix_data_o,
  input  logic              flush_i,
  output logic [ADDR_W:0]   level_o,
  output logic [15:0]       underflow_cnt_o
);
  localparam logic [ADDR_W:0] START_LVL = (ADDR_W+1)'(START_LEVEL);

  sink_state_e state;
  logic        full, empty, accept, pop;
  logic [7:0]  head;

  // The PPU keeps strobe high during the ack cycle, so a raised ack blocks
  // a second push of the same byte. Full is taken before any pop this
  // cycle, so a freed slot is only offered on the following cycle.
  assign accept = px_stb_i && !px_ack_o && !full && !flush_i;
  assign pop    = (state == RUN) && pix_rd_i && !empty && !flush_i;

  ppu_sink_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (accept),
    .wdata (px_data_i),
    .pop   (pop),
    .rdata (head),
    .level (level_o),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      px_ack_o        <= 1'b0;
      pix_data_o      <= BLACK_PIX;
      state           <= PRIME;
      underflow_cnt_o <= '0;
    end else if (flush_i) begin
      // Underflow history survives a flush.
      px_ack_o   <= 1'b0;
      pix_data_o <= BLACK_PIX;
      state      <= PRIME;
    end else begin
      px_ack_o <= accept;
      case (state)
        PRIME: begin
          // No pops while priming, so the post-edge level is level + push.
          if (level_o + {{ADDR_W{1'b0}}, accept} >= START_LVL) state <= RUN;
        end
        RUN: begin
          if (pix_rd_i) begin
            if (!empty) pix_data_o <= head;
            else begin
              pix_data_o <= BLACK_PIX;
              if (underflow_cnt_o != 16'hFFFF)
                underflow_cnt_o <= underflow_cnt_o + 16'd1;
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end
endmodule
